rr_bus_arbiter: RTL and testbench

- Shares one single-port register bus among NUM_REQ requesters.
- The bus is the en/wr/addr/wdata/rdata style interface our DUTs expose; the arbiter drives it.
- Round-robin arbitration; sequences one write or read transaction at a time.
- Each requester gets a one-cycle completion ack; read data is returned with that ack.

---
 rtl/rr_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rr_bus_arbiter
//
// Lets NUM_REQ requesters share a single-port register bus
// (en/wr/addr/wdata/rdata). One transaction is in flight at a time. The
// winner is chosen round-robin, starting after the last requester served.
// The owner gets a one-cycle ack when the transaction completes. For a read,
// the data is returned on rdata alongside that ack.
//
// Transaction shape (req sampled in IDLE at cycle T):
//   write : CMD T+1, ACK T+2, IDLE T+3
//   read  : CMD T+1, WAIT T+2 .. T+1+RD_LAT, ACK T+2+RD_LAT, then IDLE
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   req        per-requester request level
//   req_wr     per-requester direction (1 = write, 0 = read)
//   req_addr   flattened addresses, requester i at [i*AW +: AW]
//   req_wdata  flattened write data, requester i at [i*DW +: DW]
//   gnt        one-hot owner of the transaction in flight (CMD..ACK)
//   ack        one-hot, one-cycle completion pulse
//   rdata      data of the most recently completed read
//   busy       high whenever a transaction is in flight
//   bus_en     bus enable (CMD cycle only)
//   bus_wr     bus write strobe
//   bus_addr   bus address
//   bus_wdata  bus write data
//   bus_rdata  bus read data, valid RD_LAT cycles after the command cycle
// -----------------------------------------------------------------------------
module rr_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  bus_en,
    output logic                  bus_wr,
    output logic [AW-1:0]         bus_addr,
    output logic [DW-1:0]         bus_wdata,
    input  logic [DW-1:0]         bus_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_t;

    // Payload of the requester that would win if arbitration happened now.
    typedef struct packed {
        logic [IW-1:0] idx;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xact_t;

    state_t        state;
    logic [IW-1:0] ptr;      // last requester served; search starts after it
    logic [CW-1:0] cnt;      // remaining WAIT cycles, RD_LAT down to 1
    logic          cur_wr;   // direction of the transaction in flight

    logic [NUM_REQ-1:0][AW-1:0] addr_arr;
    logic [NUM_REQ-1:0][DW-1:0] wdata_arr;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    // Round-robin pick: walk ptr+1, ptr+2, ... with wrap and take the first
    // requester that has req set.
    logic [IW-1:0] cand;
    logic          found;
    xact_t         pick;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick.idx   = cand;
                pick.wr    = req_wr[cand];
                pick.addr  = addr_arr[cand];
                pick.wdata = wdata_arr[cand];
            end
        end
    end

    // Control FSM. Every output is a register. The bus fields are loaded on
    // the IDLE->CMD edge, so they are valid exactly in the CMD cycle. They
    // are cleared on the edge that leaves CMD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            cnt       <= '0;
            cur_wr    <= 1'b0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            bus_en    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= CMD;
                        ptr       <= pick.idx;
                        cur_wr    <= pick.wr;
                        gnt       <= ONE_HOT0 << pick.idx;
                        busy      <= 1'b1;
                        bus_en    <= 1'b1;
                        bus_wr    <= pick.wr;
                        bus_addr  <= pick.addr;
                        bus_wdata <= pick.wdata;
                    end
                end
                CMD: begin
                    bus_en    <= 1'b0;
                    bus_wr    <= 1'b0;
                    bus_addr  <= '0;
                    bus_wdata <= '0;
                    if (cur_wr) begin
                        state <= ACK;
                        ack   <= gnt;
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(RD_LAT);
                    end
                end
                WAIT: begin
                    // cnt == 1 marks the cycle in which bus_rdata is valid.
                    if (cnt == CW'(1)) begin
                        state <= ACK;
                        rdata <= bus_rdata;
                        ack   <= gnt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_bus_arbiter
//
// The driver issues stimulus one cycle at a time. It also steps a
// transaction-level reference model, which pushes the expected bus command
// and the expected ack into queues and records the expected grant for each
// cycle. A separate monitor runs on the falling edge. It pops and compares
// whenever the DUT shows a bus command or an ack. An attached bus model is a
// simple memory that returns read data RD_LAT cycles after the command cycle
// and returns noise at other times.
// -----------------------------------------------------------------------------
module tb_rr_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int RD_LAT  = 2;
    localparam int MAXC    = 4096;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ-1:0]    req_wr = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    gnt, ack;
    logic [DW-1:0]         rdata;
    logic                  busy, bus_en, bus_wr;
    logic [AW-1:0]         bus_addr;
    logic [DW-1:0]         bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .bus_en(bus_en), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- bus model ----------------
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h44) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    logic [DW-1:0] bus_mem [256];
    logic          rd_v [1:RD_LAT];
    logic [AW-1:0] rd_a [1:RD_LAT];
    logic [DW-1:0] noise = '0;

    initial for (int i = 0; i < 256; i++) bus_mem[i] = init_val(AW'(i));

    always @(posedge clk) begin
        if (bus_en && bus_wr) bus_mem[bus_addr] <= bus_wdata;
        for (int i = RD_LAT; i > 1; i--) begin
            rd_v[i] <= rd_v[i-1];
            rd_a[i] <= rd_a[i-1];
        end
        rd_v[1] <= bus_en && !bus_wr;
        rd_a[1] <= bus_addr;
        noise   <= DW'($urandom);
    end

    assign bus_rdata = (rd_v[RD_LAT] === 1'b1) ? bus_mem[rd_a[RD_LAT]] : noise;

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int            cyc;
        int            idx;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] rdata;
    } ack_t;

    cmd_t cmd_q[$];
    ack_t ack_q[$];
    logic [NUM_REQ-1:0] exp_gnt [MAXC];
    logic [DW-1:0]      m_mem [256];
    int                 m_ptr = NUM_REQ - 1;
    int                 m_next_idle = 0;
    logic [DW-1:0]      m_rdata = '0;
    int                 gnt_log[$];
    int                 cmd_cyc_log[$];
    bit                 mon_on = 1'b0;

    // Evaluates the inputs of the current cycle, which the DUT samples at the
    // next rising edge.
    task automatic model_cycle();
        int   win;
        int   ack_cyc;
        cmd_t c;
        ack_t a;
        win = -1;
        ack_cyc = 0;
        if (rst) begin
            for (int i = cmd_q.size() - 1; i >= 0; i--) if (cmd_q[i].cyc > cyc) cmd_q.delete(i);
            for (int i = ack_q.size() - 1; i >= 0; i--) if (ack_q[i].cyc > cyc) ack_q.delete(i);
            for (int k = cyc + 1; k <= cyc + 8; k++) if (k < MAXC) exp_gnt[k] = '0;
            m_ptr       = NUM_REQ - 1;
            m_next_idle = cyc + 1;
            m_rdata     = '0;
        end else if (cyc >= m_next_idle && req != '0) begin
            for (int k = 1; k <= NUM_REQ; k++)
                if (win < 0 && ((req >> ((m_ptr + k) % NUM_REQ)) & 1) != 0)
                    win = (m_ptr + k) % NUM_REQ;
            c.cyc  = cyc + 1;
            c.idx  = win;
            c.wr   = ((req_wr >> win) & 1) != 0;
            c.addr = AW'(req_addr >> (win * AW));
            c.data = DW'(req_wdata >> (win * DW));
            if (c.wr) begin
                m_mem[c.addr] = c.data;
                ack_cyc = cyc + 2;
            end else begin
                m_rdata = m_mem[c.addr];
                ack_cyc = cyc + 2 + RD_LAT;
            end
            a.cyc   = ack_cyc;
            a.idx   = win;
            a.rdata = m_rdata;
            cmd_q.push_back(c);
            ack_q.push_back(a);
            for (int k = cyc + 1; k <= ack_cyc; k++) if (k < MAXC) exp_gnt[k] = NUM_REQ'(1) << win;
            m_ptr       = win;
            m_next_idle = ack_cyc + 1;
        end
    endtask

    // ---------------- monitor ----------------
    cmd_t ce;
    ack_t ae;
    int   gi;

    always @(negedge clk) begin
        if (mon_on && cyc < MAXC) begin
            chk("gnt", 32'(gnt), 32'(exp_gnt[cyc]));
            chk("busy", 32'(busy), 32'(exp_gnt[cyc] != '0));
            gi = -1;
            for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gi = i;

            while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
                chk("cmd_missed", 32'(cmd_q[0].cyc), 32'(cyc));
                void'(cmd_q.pop_front());
            end
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                ce = cmd_q.pop_front();
                chk("bus_en", 32'(bus_en), 32'd1);
                chk("bus_wr", 32'(bus_wr), 32'(ce.wr));
                chk("bus_addr", 32'(bus_addr), 32'(ce.addr));
                if (ce.wr) chk("bus_wdata", 32'(bus_wdata), 32'(ce.data));
                chk("cmd_gnt", 32'(gnt), 32'd1 << ce.idx);
                gnt_log.push_back(gi);
                cmd_cyc_log.push_back(cyc);
            end else begin
                chk("bus_idle", 32'({bus_en, bus_wr, bus_addr, bus_wdata}), 32'd0);
            end

            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                chk("ack_missed", 32'(ack_q[0].cyc), 32'(cyc));
                void'(ack_q.pop_front());
            end
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                ae = ack_q.pop_front();
                chk("ack", 32'(ack), 32'd1 << ae.idx);
                chk("ack_rdata", 32'(rdata), 32'(ae.rdata));
            end else begin
                chk("ack_idle", 32'(ack), 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [NUM_REQ-1:0] rq, input logic [NUM_REQ-1:0] wr,
                        input logic [NUM_REQ*AW-1:0] a, input logic [NUM_REQ*DW-1:0] d);
        @(posedge clk);
        #1;
        rst       = r;
        req       = rq;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        model_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, '0, '0);
    endtask

    function automatic logic [NUM_REQ*AW-1:0] rnd_addr(input int lim);
        logic [NUM_REQ-1:0][AW-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i] = AW'($urandom_range(0, lim));
        return v;
    endfunction

    function automatic logic [NUM_REQ*DW-1:0] rnd_data();
        logic [NUM_REQ-1:0][DW-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i] = DW'($urandom);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0][AW-1:0] av;
        logic [NUM_REQ-1:0][DW-1:0] dv;
        logic [NUM_REQ-1:0]         rq;
        int                         dens;

        for (int i = 0; i < 256; i++) m_mem[i] = init_val(AW'(i));
        for (int k = 0; k < MAXC; k++) exp_gnt[k] = '0;

        // Reset for three cycles, then every output must read zero.
        repeat (3) step(1'b1, '0, '0, '0, '0);
        step(1'b0, '0, '0, '0, '0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus", 32'({bus_en, bus_wr, bus_addr, bus_wdata}), 32'd0);
        mon_on = 1'b1;

        // All four requesters write continuously.
        gnt_log.delete();
        cmd_cyc_log.delete();
        repeat (20) step(1'b0, 4'b1111, 4'b1111, rnd_addr(8'h3F), rnd_data());
        idle(8);
        chk("rr_count", 32'(gnt_log.size() >= 6), 32'd1);
        if (gnt_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", 32'(gnt_log[i]), 32'(i % NUM_REQ));
            for (int i = 1; i < 6; i++) chk("rr_spacing", 32'(cmd_cyc_log[i] - cmd_cyc_log[i-1]), 32'd3);
        end

        // Requester 2 writes 0x11 to 0x16.
        av = '0; dv = '0; av[2] = 8'h16; dv[2] = 8'h11;
        step(1'b0, 4'b0100, 4'b0100, av, dv);
        idle(1);
        chk("wr_bus_en", 32'(bus_en), 32'd1);
        chk("wr_bus_wr", 32'(bus_wr), 32'd1);
        chk("wr_bus_addr", 32'(bus_addr), 32'h16);
        chk("wr_bus_wdata", 32'(bus_wdata), 32'h11);
        chk("wr_gnt", 32'(gnt), 32'b0100);
        idle(1);
        chk("wr_ack", 32'(ack), 32'b0100);
        idle(1);
        chk("wr_busy_done", 32'(busy), 32'd0);

        // Requester 1 reads 0x44 (memory holds 0xA5), then requester 0 writes.
        av = '0; av[1] = 8'h44;
        step(1'b0, 4'b0010, 4'b0000, av, rnd_data());
        idle(1);
        chk("rd_bus_en", 32'(bus_en), 32'd1);
        chk("rd_bus_wr", 32'(bus_wr), 32'd0);
        chk("rd_bus_addr", 32'(bus_addr), 32'h44);
        idle(3);
        chk("rd_ack", 32'(ack), 32'b0010);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        av = '0; dv = '0; av[0] = 8'h20; dv[0] = 8'h77;
        step(1'b0, 4'b0001, 4'b0001, av, dv);
        idle(2);
        chk("wr0_ack", 32'(ack), 32'b0001);
        chk("rdata_hold", 32'(rdata), 32'hA5);

        // Requester 0 was served last, so 3 beats 0 when both ask together.
        gnt_log.delete();
        repeat (4) step(1'b0, 4'b1001, 4'b1001, rnd_addr(8'h3F), rnd_data());
        idle(6);
        chk("pri_count", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() >= 2) begin
            chk("pri_first", 32'(gnt_log[0]), 32'd3);
            chk("pri_second", 32'(gnt_log[1]), 32'd0);
        end

        // Reset pulse during the first WAIT cycle of a read by requester 2.
        av = '0; av[2] = 8'h30;
        step(1'b0, 4'b0100, 4'b0000, av, rnd_data());
        idle(1);
        step(1'b1, '0, '0, '0, '0);
        gnt_log.delete();
        step(1'b0, 4'b0101, 4'b0101, rnd_addr(8'h3F), rnd_data());
        chk("rstw_ack", 32'(ack), 32'd0);
        chk("rstw_bus_en", 32'(bus_en), 32'd0);
        chk("rstw_gnt", 32'(gnt), 32'd0);
        chk("rstw_rdata", 32'(rdata), 32'd0);
        repeat (3) step(1'b0, 4'b0101, 4'b0101, rnd_addr(8'h3F), rnd_data());
        idle(8);
        chk("rstw_count", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() >= 2) begin
            chk("rstw_first", 32'(gnt_log[0]), 32'd0);
            chk("rstw_second", 32'(gnt_log[1]), 32'd2);
        end

        // Randomized traffic with varying density and occasional resets.
        for (int n = 0; n < 700; n++) begin
            dens = (n / 100) % 4;
            for (int i = 0; i < NUM_REQ; i++) rq[i] = ($urandom_range(0, 3) <= dens);
            step(($urandom_range(0, 149) == 0), rq, NUM_REQ'($urandom), rnd_addr(8'h4F), rnd_data());
        end
        idle(12);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
